// File: rtl/bit2_divider_seq.sv
// bit2_divider_seq: multi-cycle restoring divider, one quotient bit per clock, MSB first
module bit2_divider_seq #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;
  logic [DW-1:0] q_w;
  logic [VW-1:0] dvs;
  logic [VW-1:0] part;
  logic [VW:0]   part_sh;
  logic          ge;
  logic [VW-1:0] part_nx;
  logic [DW-1:0] q_nx;
  // one restoring step: the partial remainder stays below the divisor, so VW bits hold it between steps
  always_comb begin
    part_sh = {part, dvd[DW-1]};
    ge      = part_sh >= {1'b0, dvs};
    part_nx = ge ? VW'(part_sh - {1'b0, dvs}) : part_sh[VW-1:0];
    q_nx    = (q_w << 1) | DW'(ge);
  end
  // control FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q_w         <= '0;
      part        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && divisor != '0) begin
            dvd   <= dividend;
            dvs   <= divisor;
            q_w   <= '0;
            part  <= '0;
            cnt   <= CW'(DW - 1);
            busy  <= 1'b1;
            state <= CALC;
          end else if (start) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b1;
            state       <= DONE;
          end
        end
        CALC: begin
          part <= part_nx;
          q_w  <= q_nx;
          dvd  <= dvd << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient    <= q_nx;
            remainder   <= part_nx;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit2_divider_seq.sv
// tb_bit2_divider_seq: directed vector table, exhaustive sweep and corner sequences for bit2_divider_seq
module tb_bit2_divider_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [1:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient;
  logic [1:0] remainder;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [1:0] b;
    logic [3:0] q;
    logic [1:0] r;
    logic       z;
    int         lat;
  } vec_t;
  vec_t tv[10];

  always #5 clk = ~clk;

  bit2_divider_seq #(.DW(4), .VW(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge where done is seen
  task automatic run_op(input logic [3:0] a, input logic [1:0] b, output int lat);
    logic [3:0] pq;
    logic [1:0] pr;
    pq = quotient;
    pr = remainder;
    dividend = a;
    divisor = b;
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      dividend = ~a;
      divisor = ~b;
      lat++;
      if (!done) begin
        chk("hold_q", 32'(quotient), 32'(pq));
        chk("hold_r", 32'(remainder), 32'(pr));
        chk("busy_calc", 32'(busy), 1);
      end
    end while (!done && lat < 12);
    chk("done_seen", 32'(done), 1);
  endtask

  initial begin
    int lat, n, nd;
    logic [3:0] eq;
    logic [1:0] er;
    tv[0] = '{4'd13, 2'd3, 4'd4,  2'd1, 1'b0, 5};
    tv[1] = '{4'd9,  2'd0, 4'd15, 2'd0, 1'b1, 1};
    tv[2] = '{4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 5};
    tv[3] = '{4'd0,  2'd3, 4'd0,  2'd0, 1'b0, 5};
    tv[4] = '{4'd15, 2'd3, 4'd5,  2'd0, 1'b0, 5};
    tv[5] = '{4'd7,  2'd2, 4'd3,  2'd1, 1'b0, 5};
    tv[6] = '{4'd14, 2'd3, 4'd4,  2'd2, 1'b0, 5};
    tv[7] = '{4'd1,  2'd2, 4'd0,  2'd1, 1'b0, 5};
    tv[8] = '{4'd0,  2'd0, 4'd15, 2'd0, 1'b1, 1};
    tv[9] = '{4'd2,  2'd3, 4'd0,  2'd2, 1'b0, 5};
    #1;
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].a, tv[i].b, lat);
      chk($sformatf("vec%0d_q", i), 32'(quotient), 32'(tv[i].q));
      chk($sformatf("vec%0d_r", i), 32'(remainder), 32'(tv[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(tv[i].z));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), 32'(done), 0);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 0);
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 2'd0 : 2'(a % b);
        run_op(4'(a), 2'(b), lat);
        chk($sformatf("sw%0d_%0d_q", a, b), 32'(quotient), 32'(eq));
        chk($sformatf("sw%0d_%0d_r", a, b), 32'(remainder), 32'(er));
        chk($sformatf("sw%0d_%0d_dbz", a, b), 32'(div_by_zero), 32'(b == 0));
        if (b != 0) chk($sformatf("sw%0d_%0d_id", a, b), 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        @(negedge clk);
      end
    end
    dividend = 4'd13;
    divisor = 2'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd6;
    divisor = 2'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("ign_lat", 32'(n), 2);
    chk("ign_q", 32'(quotient), 4);
    chk("ign_r", 32'(remainder), 1);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("ign_extra_done", 32'(nd), 0);
    chk("ign_idle", 32'(busy), 0);
    dividend = 4'd15;
    divisor = 2'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(quotient), 0);
    chk("arst_r", 32'(remainder), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_dbz", 32'(div_by_zero), 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(done);
    end
    rst_n = 1'b1;
    run_op(4'd2, 2'd3, lat);
    chk("post_rst_q", 32'(quotient), 0);
    chk("post_rst_r", 32'(remainder), 2);
    chk("post_rst_lat", 32'(lat), 5);
    chk("abort_no_done", 32'(nd), 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit2_divider_seq.md
BIT2_DIVIDER_SEQ -- requirements
Module: bit2_divider_seq

Interface
REQ-001 Parameter DW, default 4, dividend and quotient width.
REQ-002 Parameter VW, default 2, divisor and remainder width; DW >= VW >= 1 SHALL hold.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 dividend  input  DW  unsigned dividend; captured when start is accepted.
REQ-007 divisor  input  VW  unsigned divisor; captured when start is accepted.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 quotient  output  DW  unsigned quotient.
REQ-011 remainder  output  VW  unsigned remainder.
REQ-012 div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-013 The block SHALL be the inverse of the team's 2-bit multiplier: for divisor != 0, quotient*divisor + remainder == dividend and remainder < divisor.
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 IDLE with start=1 and divisor!=0 SHALL capture the operands, clear the quotient/partial-remainder working registers, load iteration counter = DW-1, and go to CALC.
REQ-016 IDLE with start=1 and divisor==0 SHALL go directly to DONE with quotient = all ones, remainder = 0 and div_by_zero = 1.
REQ-017 CALC SHALL perform one restoring step per cycle, MSB of dividend first, using a (VW+1)-bit partial remainder: shift in the next dividend bit; if partial >= divisor, subtract and shift 1 into the quotient, else shift 0.
REQ-018 CALC SHALL last exactly DW cycles (counter reaches 0), then go to DONE.
REQ-019 DONE SHALL last one cycle, assert done=1, and return to IDLE unconditionally.
REQ-020 Latency: with start sampled at edge E, done SHALL be high in the cycle after edge E+DW (normal) or after edge E (divide-by-zero).
REQ-021 quotient, remainder and div_by_zero SHALL update only on entry to DONE and SHALL hold until the next DONE; they SHALL not change during CALC.
REQ-022 start while busy=1 (CALC or DONE) SHALL be ignored; no queuing.
REQ-023 start in the IDLE cycle right after DONE SHALL be accepted (back-to-back operations).
REQ-024 Operand input changes after capture SHALL not affect the current result.
REQ-025 busy SHALL be 1 in CALC and DONE, 0 in IDLE; done SHALL never be high outside DONE.
REQ-026 div_by_zero SHALL be 0 on every normal completion.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all working registers.
REQ-028 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.
REQ-029 rst_n deassertion SHALL take effect at the next rising edge; start sampled on that edge SHALL be accepted.

Verification
REQ-030 dividend=13, divisor=3, start one cycle -> done high one cycle, 5 cycles after start sampled (DW=4); quotient=4, remainder=1, div_by_zero=0.
REQ-031 dividend=9, divisor=0 -> done in the next cycle; quotient=15, remainder=0, div_by_zero=1.
REQ-032 Exhaustive sweep of all 16x4 operand pairs, back-to-back starts -> every result matches a/b and a%b (dbz rule for b=0); quotient*divisor+remainder==dividend.
REQ-033 start pulsed again during CALC with different operands -> ignored; result reflects the first operands; no extra done.
REQ-034 rst_n pulsed low in the 2nd CALC cycle of 15/2 -> outputs 0 asynchronously, no done; then 2/3 -> quotient=0, remainder=2.
REQ-035 Operands changed the cycle after capture of 14/3 -> result stays quotient=4, remainder=2.
